// File: rtl/writeback_regfile_if.sv
// Commit, register-read and status signals between the SEQ execute/memory
// stages and the writeback/register-file block.
interface writeback_regfile_if #(
  parameter int CNT_W = 32
);
  logic             wb_valid;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic             cnd;
  logic             zf_in;
  logic             sf_in;
  logic             of_in;
  logic [63:0]      vale;
  logic [63:0]      valm;
  logic [3:0]       dste;
  logic [3:0]       dstm;
  logic             dmem_error;
  logic [3:0]       srca;
  logic [3:0]       srcb;
  logic [63:0]      vala;
  logic [63:0]      valb;
  logic             zf;
  logic             sf;
  logic             of;
  logic [2:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output wb_valid, icode, ifun, cnd, zf_in, sf_in, of_in,
    output vale, valm, dste, dstm, dmem_error, srca, srcb,
    input  vala, valb, zf, sf, of, stat, halted, retired
  );

  modport slave (
    input  wb_valid, icode, ifun, cnd, zf_in, sf_in, of_in,
    input  vale, valm, dste, dstm, dmem_error, srca, srcb,
    output vala, valb, zf, sf, of, stat, halted, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ back end: commits execute/memory results to the register file and
// condition codes, tracks processor status and counts retired instructions.
module writeback_regfile #(
  parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0100,
  parameter int          CNT_W    = 32
) (
  input logic               clk,
  input logic               rst_n,
  writeback_regfile_if.slave bus
);

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic {
    RUN,
    STOPPED
  } state_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_ADR,
    K_INS,
    K_HLT,
    K_NORM
  } kind_e;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_LAST   = 4'hB;
  localparam int         NREGS    = 15;

  state_e           state_q, state_d;
  stat_e            stat_q, stat_d;
  kind_e            kind;
  logic             we_e, we_m, cc_we, retire_inc;
  logic [63:0]      regs [NREGS];
  logic             zf_q, sf_q, of_q;
  logic [CNT_W-1:0] retired_q;
  logic [63:0]      vala_c, valb_c;

  // ifun carries no meaning for writeback; only icode classifies a commit.
  logic unused_ifun;
  assign unused_ifun = ^bus.ifun;

  // Commit classification, highest priority first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    kind = K_NONE;
    if (bus.wb_valid && state_q == RUN) begin
      if (bus.dmem_error)       kind = K_ADR;
      else if (bus.icode > I_LAST) kind = K_INS;
      else if (bus.icode == I_HALT) kind = K_HLT;
      else                      kind = K_NORM;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= RUN;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
    end
  end

  // FSM next state: any fault or halt stops the machine until reset.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    unique case (kind)
      K_ADR:   begin state_d = STOPPED; stat_d = STAT_ADR; end
      K_INS:   begin state_d = STOPPED; stat_d = STAT_INS; end
      K_HLT:   begin state_d = STOPPED; stat_d = STAT_HLT; end
      K_NORM:  begin state_d = RUN;     stat_d = STAT_AOK; end
      default: ;
    endcase
  end

  // FSM outputs: write enables for the datapath.
  always_comb begin
    we_e       = 1'b0;
    we_m       = 1'b0;
    cc_we      = 1'b0;
    retire_inc = 1'b0;
    if (kind == K_HLT) begin
      retire_inc = 1'b1;
    end else if (kind == K_NORM) begin
      retire_inc = 1'b1;
      we_e       = (bus.dste != REG_NONE) && (bus.icode != I_CMOV || bus.cnd);
      we_m       = (bus.dstm != REG_NONE);
      cc_we      = (bus.icode == I_OPQ);
    end
  end

  // Register file. M-port is written after E-port so it wins on a shared
  // destination (popq %rsp loads the popped value, not the incremented sp).
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this array is reset on purpose: architectural state must start at known values.
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == int'(REG_RSP)) ? RSP_INIT : 64'h0;
      end
    end else begin
      if (we_e) regs[bus.dste] <= bus.vale;
      if (we_m) regs[bus.dstm] <= bus.valm;
    end
  end

  // Condition codes and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      if (cc_we) begin
        zf_q <= bus.zf_in;
        sf_q <= bus.sf_in;
        of_q <= bus.of_in;
      end
      if (retire_inc) retired_q <= retired_q + 1'b1;
    end
  end

  // Combinational read ports, no bypass from the commit in flight.
  always_comb begin
    vala_c = 64'h0;
    valb_c = 64'h0;
    if (bus.srca != REG_NONE) vala_c = regs[bus.srca];
    if (bus.srcb != REG_NONE) valb_c = regs[bus.srcb];
  end

  assign bus.vala    = vala_c;
  assign bus.valb    = valb_c;
  assign bus.zf      = zf_q;
  assign bus.sf      = sf_q;
  assign bus.of      = of_q;
  assign bus.stat    = stat_q;
  assign bus.halted  = (stat_q != STAT_AOK);
  assign bus.retired = retired_q;

endmodule
